// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types for the SDRAM read-port arbiters: FSM states, bus widths
// and the 3-bit slot index.
package jtframe_arb_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  typedef logic [2:0] slot_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/jtframe_sdram_arb_if.sv
// Slot-side and SDRAM-side bus of the ROM arbiter.
// master is the arbiter, slave is the requesters plus SDRAM controller.
interface jtframe_sdram_arb_if
  import jtframe_arb_pkg::*;
#(
  parameter int SLOTS = 5
);
  logic                      downloading;
  logic [SLOTS-1:0]          slot_req;
  logic [SLOTS*ADDR_W-1:0]   slot_addr;
  logic [SLOTS-1:0]          slot_ok;
  logic [DATA_W-1:0]         slot_data;
  logic                      sdram_req;
  logic [ADDR_W-1:0]         sdram_addr;
  logic                      sdram_ack;
  logic                      data_rdy;
  logic [DATA_W-1:0]         data_read;
  logic                      timeout_err;

  modport master (
    input  downloading, slot_req, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_data, sdram_req, sdram_addr, timeout_err
  );

  modport slave (
    output downloading, slot_req, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_data, sdram_req, sdram_addr, timeout_err
  );
endinterface

// File: rtl/jtframe_sdram_arb_rr_pick.sv
// Combinational round-robin selector with absolute-priority override.
// Priority slots win lowest-index first; otherwise the first requester after last_grant.
module jtframe_rr_pick
  import jtframe_arb_pkg::*;
#(
  parameter int SLOTS = 5
) (
  input  logic [SLOTS-1:0] req,
  input  logic [7:0]       prio_mask,
  input  slot_t            last_grant,
  output logic             valid,
  output slot_t            index
);

  logic [7:0] r8;
  logic [7:0] p8;

  assign r8    = 8'(req);
  assign p8    = r8 & prio_mask;
  assign valid = |req;

  always_comb begin
    logic hit;
    int   j;
    hit   = 1'b0;
    j     = 0;
    index = '0;
    for (int i = 0; i < 8; i++) begin
      if (!hit && p8[3'(i)]) begin
        hit   = 1'b1;
        index = slot_t'(i);
      end
    end
    // cyclic scan starting just after the previous winner, ending on it
    for (int k = 1; k <= SLOTS; k++) begin
      j = int'(last_grant) + k;
      if (j >= SLOTS) j = j - SLOTS;
      if (!hit && j < SLOTS && r8[3'(j)]) begin
        hit   = 1'b1;
        index = slot_t'(j);
      end
    end
  end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Shares the SDRAM read port among up to eight ROM fetch slots, with a
// watchdog so a lost data_rdy cannot lock the bus.
module jtframe_sdram_arb
  import jtframe_arb_pkg::*;
#(
  parameter int         SLOTS     = 5,
  parameter logic [7:0] PRIO_MASK = 8'h10,
  parameter int         TIMEOUT   = 63
) (
  input logic               clk,
  input logic               rst_n,
  jtframe_sdram_arb_if.master bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [SLOTS-1:0] ONE     = SLOTS'(1);
  localparam logic [7:0]       WD_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        st;
  slot_t             grant;
  slot_t             last_grant;
  logic [7:0]        wd_cnt;
  logic              req_r;
  logic [ADDR_W-1:0] addr_r;
  logic [SLOTS-1:0]  ok_r;
  logic [DATA_W-1:0] data_r;
  logic              err_r;

  logic              pick_vld;
  slot_t             pick_idx;
  logic [7:0]        req8;
  logic [ADDR_W-1:0] addr_a [8];

  assign req8 = 8'(bus.slot_req);

  for (genvar g = 0; g < 8; g++) begin : g_addr
    if (g < SLOTS) begin : g_real
      assign addr_a[g] = bus.slot_addr[g*ADDR_W +: ADDR_W];
    end else begin : g_pad
      assign addr_a[g] = '0;
    end
  end

  jtframe_rr_pick #(.SLOTS(SLOTS)) u_pick (
    .req        (bus.slot_req),
    .prio_mask  (PRIO_MASK),
    .last_grant (last_grant),
    .valid      (pick_vld),
    .index      (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      grant      <= '0;
      last_grant <= slot_t'(SLOTS - 1);
      wd_cnt     <= '0;
      req_r      <= 1'b0;
      addr_r     <= '0;
      ok_r       <= '0;
      data_r     <= '0;
      err_r      <= 1'b0;
    end else begin
      ok_r <= '0;
      case (st)
        S_IDLE: if (!bus.downloading && pick_vld) begin
          grant  <= pick_idx;
          addr_r <= addr_a[pick_idx];
          req_r  <= 1'b1;
          st     <= S_REQ;
        end
        S_REQ: begin
          // download aborts before the ack; last_grant is left alone
          if (bus.downloading) begin
            req_r <= 1'b0;
            st    <= S_IDLE;
          end else if (bus.sdram_ack) begin
            req_r  <= 1'b0;
            wd_cnt <= '0;
            st     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.data_rdy) begin
            data_r <= bus.data_read;
            ok_r   <= req8[grant] ? (ONE << grant) : '0;
            st     <= S_DONE;
          end else if (wd_cnt == WD_LAST) begin
            err_r      <= 1'b1;
            last_grant <= grant;
            st         <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        S_DONE: begin
          last_grant <= grant;
          st         <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.sdram_req   = req_r;
  assign bus.sdram_addr  = addr_r;
  assign bus.slot_ok     = ok_r;
  assign bus.slot_data   = data_r;
  assign bus.timeout_err = err_r;

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Bench for jtframe_sdram_arb: vector table, directed corner sequences and
// a randomized run scored against a transaction-level arbitration model.
module tb_jtframe_sdram_arb;
  import jtframe_arb_pkg::*;

  localparam int         SLOTS = 5;
  localparam logic [7:0] PRIO  = 8'h10;
  localparam int         TOUT  = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtframe_sdram_arb_if #(.SLOTS(SLOTS)) bus();

  jtframe_sdram_arb #(.SLOTS(SLOTS), .PRIO_MASK(PRIO), .TIMEOUT(TOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [21:0] addr_v [SLOTS];
  always_comb begin
    bus.slot_addr = '0;
    for (int i = 0; i < SLOTS; i++) bus.slot_addr[22*i +: 22] = addr_v[i];
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  req;
    logic [15:0] data;
    int          ack_dly;
    int          rdy_dly;
    int          exp_slot;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // spec rule: priority slots lowest-first, else first requester after last
  function automatic int model_pick(input logic [4:0] r, input int last);
    for (int i = 0; i < SLOTS; i++)
      if (r[3'(i)] && PRIO[3'(i)]) return i;
    for (int k = 1; k <= SLOTS; k++)
      if (r[3'((last + k) % SLOTS)]) return (last + k) % SLOTS;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.slot_req = '0;
    bus.sdram_ack = 1'b0;
    bus.data_rdy = 1'b0;
    bus.downloading = 1'b0;
    #2;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input logic [21:0] exp_addr, input logic [4:0] exp_ok,
                         input logic [15:0] d, input int ack_dly, input int rdy_dly,
                         input logic [4:0] wd_mask);
    int n;
    n = 0;
    while (!bus.sdram_req && n < 16) begin
      tick();
      n++;
    end
    chk("sdram_req_rise", 32'(bus.sdram_req), 1);
    if (!bus.sdram_req) return;
    chk("sdram_addr", 32'(bus.sdram_addr), 32'(exp_addr));
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk("req_held", 32'(bus.sdram_req), 1);
      chk("addr_held", 32'(bus.sdram_addr), 32'(exp_addr));
    end
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    chk("req_drop_on_ack", 32'(bus.sdram_req), 0);
    bus.slot_req = bus.slot_req & ~wd_mask;
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk("no_early_ok", 32'(bus.slot_ok), 0);
    end
    bus.data_read = d;
    bus.data_rdy = 1'b1;
    tick();
    bus.data_rdy = 1'b0;
    chk("slot_ok", 32'(bus.slot_ok), 32'(exp_ok));
    chk("slot_data", 32'(bus.slot_data), 32'(d));
    tick();
    chk("slot_ok_one_cycle", 32'(bus.slot_ok), 0);
  endtask

  initial begin
    int         n;
    int         to_at;
    logic       any;
    logic [4:0] pend, prev_req;
    int         cur, phase, wcnt, model_last;
    logic       expect_ok;
    logic [15:0] exp_data;

    bus.slot_req = '0;
    bus.downloading = 1'b0;
    bus.sdram_ack = 1'b0;
    bus.data_rdy = 1'b0;
    bus.data_read = '0;
    addr_v = '{22'h000A00, 22'h111111, 22'h012345, 22'h3F0003, 22'h2A5554};

    vecs[0] = '{5'b00100, 16'hBEEF, 3, 4, 2};
    vecs[1] = '{5'b10001, 16'h1234, 0, 0, 4};
    vecs[2] = '{5'b00110, 16'hA5A5, 1, 2, 1};
    vecs[3] = '{5'b11111, 16'h0F0F, 2, 1, 4};
    vecs[4] = '{5'b01010, 16'h5555, 0, 3, 1};
    vecs[5] = '{5'b00001, 16'hFFFF, 1, 0, 0};

    // reset values
    #12;
    chk("rst_sdram_req", 32'(bus.sdram_req), 0);
    chk("rst_sdram_addr", 32'(bus.sdram_addr), 0);
    chk("rst_slot_ok", 32'(bus.slot_ok), 0);
    chk("rst_slot_data", 32'(bus.slot_data), 0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    tick();
    rst_n = 1'b1;

    // first arbitration from reset for each request pattern
    for (int v = 0; v < 6; v++) begin
      do_reset();
      bus.slot_req = vecs[v].req;
      run_txn(addr_v[vecs[v].exp_slot], 5'b1 << vecs[v].exp_slot, vecs[v].data,
              vecs[v].ack_dly, vecs[v].rdy_dly, 5'b0);
      bus.slot_req = '0;
    end

    // round robin over 0,1,2 held continuously
    do_reset();
    bus.slot_req = 5'b00111;
    for (int i = 0; i < 6; i++)
      run_txn(addr_v[i % 3], 5'b1 << (i % 3), 16'(16'h1000 + i), 1, 1, 5'b0);
    bus.slot_req = '0;

    // priority slot 4 starves slot 0 until it drops
    do_reset();
    bus.slot_req = 5'b10001;
    for (int i = 0; i < 3; i++)
      run_txn(addr_v[4], 5'b10000, 16'(16'h4000 + i), 0, 1, 5'b0);
    bus.slot_req = 5'b00001;
    run_txn(addr_v[0], 5'b00001, 16'h0001, 0, 1, 5'b0);
    bus.slot_req = '0;

    // watchdog
    do_reset();
    bus.slot_req = 5'b00010;
    n = 0;
    while (!bus.sdram_req && n < 16) begin tick(); n++; end
    chk("wd_req_rise", 32'(bus.sdram_req), 1);
    chk("wd_addr", 32'(bus.sdram_addr), 32'(addr_v[1]));
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    to_at = -1;
    any = 1'b0;
    for (int t = 1; t < 70; t++) begin
      tick();
      if (bus.timeout_err && to_at < 0) begin
        to_at = t;
        bus.slot_req = '0;
      end
      any = any | (|bus.slot_ok);
    end
    chk("wd_abort_cycles", 32'(to_at), 63);
    chk("wd_no_slot_ok", 32'(any), 0);
    bus.data_read = 16'hDEAD;
    bus.data_rdy = 1'b1;
    tick();
    bus.data_rdy = 1'b0;
    chk("wd_late_rdy_ok", 32'(bus.slot_ok), 0);
    chk("wd_late_rdy_data", 32'(bus.slot_data), 0);
    chk("wd_err_sticky", 32'(bus.timeout_err), 1);

    // downloading during REQ
    do_reset();
    bus.slot_req = 5'b01000;
    tick();
    chk("dl_req_up", 32'(bus.sdram_req), 1);
    bus.downloading = 1'b1;
    tick();
    chk("dl_req_drop", 32'(bus.sdram_req), 0);
    any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      any = any | bus.sdram_req | (|bus.slot_ok);
    end
    chk("dl_no_grant", 32'(any), 0);
    bus.downloading = 1'b0;
    run_txn(addr_v[3], 5'b01000, 16'h7777, 0, 2, 5'b0);
    bus.slot_req = '0;

    // withdrawal during WAIT: silent completion, last_grant still advances
    bus.slot_req = 5'b00100;
    run_txn(addr_v[2], 5'b00000, 16'hCAFE, 1, 2, 5'b00100);
    bus.slot_req = 5'b01001;
    n = 0;
    while (!bus.sdram_req && n < 16) begin tick(); n++; end
    chk("wdraw_next_rr", 32'(bus.sdram_addr), 32'(addr_v[3]));
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    tick();

    // async reset in WAIT
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sdram_req", 32'(bus.sdram_req), 0);
    chk("mid_rst_sdram_addr", 32'(bus.sdram_addr), 0);
    chk("mid_rst_slot_ok", 32'(bus.slot_ok), 0);
    chk("mid_rst_slot_data", 32'(bus.slot_data), 0);
    chk("mid_rst_err", 32'(bus.timeout_err), 0);
    tick();
    rst_n = 1'b1;
    bus.data_read = 16'h9999;
    bus.data_rdy = 1'b1;
    tick();
    bus.data_rdy = 1'b0;
    chk("post_rst_rdy_ignored", 32'(bus.slot_ok), 0);
    chk("post_rst_data", 32'(bus.slot_data), 0);
    chk("post_rst_first_grant", 32'(bus.sdram_addr), 32'(addr_v[0]));
    run_txn(addr_v[0], 5'b00001, 16'h0BAD, 0, 0, 5'b0);
    bus.slot_req = '0;

    // randomized traffic against the transaction-level model
    do_reset();
    pend = '0;
    prev_req = '0;
    phase = 0;
    wcnt = 0;
    cur = -1;
    expect_ok = 1'b0;
    exp_data = '0;
    model_last = SLOTS - 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (expect_ok) begin
        chk("rnd_slot_ok", 32'(bus.slot_ok), 32'(5'b1 << cur));
        chk("rnd_slot_data", 32'(bus.slot_data), 32'(exp_data));
        model_last = cur;
        pend = pend & ~(5'b1 << cur);
        expect_ok = 1'b0;
        phase = 0;
      end else begin
        chk("rnd_no_ok", 32'(bus.slot_ok), 0);
      end
      if (phase == 0 && bus.sdram_req) begin
        cur = model_pick(prev_req, model_last);
        if (cur < 0) chk("rnd_unexpected_req", 32'(bus.sdram_req), 0);
        else begin
          chk("rnd_grant_addr", 32'(bus.sdram_addr), 32'(addr_v[cur]));
          phase = 1;
        end
      end
      bus.sdram_ack = 1'b0;
      bus.data_rdy = 1'b0;
      if (phase == 1) begin
        chk("rnd_req_held", 32'(bus.sdram_req), 1);
        if ($urandom_range(0, 1) == 1) begin
          bus.sdram_ack = 1'b1;
          phase = 2;
          wcnt = int'($urandom_range(0, 6));
        end
      end else if (phase == 2) begin
        chk("rnd_req_low_wait", 32'(bus.sdram_req), 0);
        if (wcnt == 0) begin
          exp_data = 16'($urandom);
          bus.data_read = exp_data;
          bus.data_rdy = 1'b1;
          expect_ok = 1'b1;
          phase = 3;
        end else wcnt--;
      end
      for (int i = 0; i < SLOTS; i++) begin
        if (!pend[3'(i)] && $urandom_range(0, 7) == 0) begin
          pend = pend | (5'b1 << i);
          addr_v[i] = 22'($urandom);
        end
      end
      bus.slot_req = pend;
      prev_req = pend;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
